mem_wb_stage_reg: RTL and testbench
===================================

Name: mem_wb_stage_reg

Overview:
- Pipeline register between the memory stage and the writeback stage.
- Captures the memory stage's results (pc, instruction, rd index, writeback data, CSR write info, trap bus) and holds them for writeback.
- Uses a 2-entry skid buffer with valid/ready handshakes, so back-pressure never cuts combinationally through to the memory stage.
- Provides a qualified bypass view of the head entry to the decode stage.

Parameters:
- XLEN, 64, data/address width
- INST_W, 32, instruction width
- RIDX_W, 5, GPR index width
- CSR_W, 12, CSR address width
- TRAP_W, 64, trap bus width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- flush_i  in  1  discard all held entries (synchronous)
- in_valid_i  in  1  memory stage has a valid result
- in_ready_o  out  1  this block can accept a result
- pc_i / inst_data_i / rd_idx_i  in  XLEN / INST_W / RIDX_W  upstream payload
- mem_data_i  in  XLEN  writeback data (load or ALU result)
- csr_addr_i / exc_csr_data_i / exc_csr_valid_i  in  CSR_W / XLEN / 1  CSR write info
- trap_bus_i  in  TRAP_W  trap bus
- out_valid_o  out  1  head entry valid
- out_ready_i  in  1  writeback accepts the head entry
- pc_o / inst_data_o / rd_idx_o / wb_data_o / csr_addr_o / exc_csr_data_o / trap_bus_o  out  widths as the inputs  head payload
- exc_csr_valid_o  out  1  stored exc_csr_valid AND out_valid_o
- byp_rd_idx_o  out  RIDX_W  head rd index when out_valid_o, else 0
- byp_data_o  out  XLEN  head writeback data

Behaviour:
- Handshakes:
  - in_fire = in_valid_i & in_ready_o
  - out_fire = out_valid_o & out_ready_i
- Storage: two payload registers, MAIN (drives the outputs) and SKID. State register, 2-bit encoding: EMPTY=0, ONE=1, FULL=2.
- Derived outputs:
  - out_valid_o = (state != EMPTY)
  - in_ready_o = (state != FULL); both derive only from the state register.
- Transitions (when flush_i = 0):
  - EMPTY: in_fire -> MAIN <= in, go to ONE.
  - ONE, in_fire & out_fire -> MAIN <= in, stay in ONE.
  - ONE, in_fire & !out_fire -> SKID <= in, go to FULL.
  - ONE, out_fire only -> go to EMPTY; MAIN payload is held, not cleared.
  - FULL: in_ready_o = 0. out_fire -> MAIN <= SKID, go to ONE.
- Latency: 1 cycle from in_fire to out_valid_o when empty. Order is strictly FIFO. Full throughput is 1 entry per cycle.
- Stability: the payload is stable while out_valid_o & !out_ready_i (required by the valid/ready protocol).
- Flush:
  - flush_i = 1 -> state <= EMPTY next cycle, regardless of in_fire/out_fire in the same cycle. The input presented that cycle is dropped.
  - Payload registers are not cleared.
  - Flush and reset have the same effect on state; reset additionally zeroes the payload.
- Bypass: byp_rd_idx_o is forced to 0 when EMPTY, so the decode stage never forwards stale data. x0 needs no special handling here; the register file ignores it.
- Reset (rst = 0, asynchronous):
  - state = EMPTY, so out_valid_o = 0 and in_ready_o = 1.
  - All payload outputs, byp_* and exc_csr_valid_o = 0.
  - Reset asserted mid-transfer drops both entries immediately.
  - Release is synchronous to clk; the first in_fire is possible on the first edge after release.
- No arithmetic; widths pass through unchanged.

Optional Feature:
- Macro: MEMWB_PERF_EN.
- When defined, adds two outputs, stall_cnt_o and bubble_cnt_o, each 64 bits, reset to 0:
  - stall_cnt_o increments every cycle with out_valid_o & !out_ready_i.
  - bubble_cnt_o increments every cycle with state == EMPTY after reset release.
  - Both counters wrap modulo 2^64 and are not cleared by flush_i.
- When not defined, the ports and counters do not exist.

Decomposition:
- Shared package (sysconfig): XLEN, INST_LEN, REG_ADDRWIDTH, CSR_REG_ADDRWIDTH, TRAP_BUS width, and the state encoding constants MWB_EMPTY, MWB_ONE, MWB_FULL.
- One natural sub-module: mwb_payload_reg, a width-parameterised payload register with load enable, used for both MAIN and SKID.

Test Plan:
- Reset: rst held low, then released → out_valid_o=0, in_ready_o=1, all outputs 0; one push of pc=0x80000000, rd=5 → out_valid_o=1 next cycle, byp_rd_idx_o=5.
- Back-pressure: out_ready_i=0, push A then B → state FULL, in_ready_o=0, outputs still show A. Raise out_ready_i → A pops, then B pops, then EMPTY.
- Streaming: in_valid_i=1 and out_ready_i=1 for 10 cycles with pc 0x0,0x4,…,0x24 → 10 outputs in order, in_ready_o never drops.
- Flush: FULL state with flush_i=1 and in_valid_i=1 in the same cycle → next cycle out_valid_o=0, byp_rd_idx_o=0, in_ready_o=1, nothing from that input appears later.
- CSR qualification: push an entry with exc_csr_valid_i=1, pop it with no new input → exc_csr_valid_o=1 only while the entry is held, then 0 once the block is EMPTY.
- Perf (MEMWB_PERF_EN defined): hold one entry with out_ready_i=0 for 7 cycles → stall_cnt_o=7; 3 idle cycles after the pop → bubble_cnt_o increments by 3.

Source files
------------

// File: rtl/sysconfig.sv
// Shared configuration for the MEM/WB stage: pipeline widths and the
// state encoding of the two-entry output skid buffer.
package sysconfig;

  localparam int XLEN              = 64;
  localparam int INST_LEN          = 32;
  localparam int REG_ADDRWIDTH     = 5;
  localparam int CSR_REG_ADDRWIDTH = 12;
  localparam int TRAP_BUS          = 64;

  typedef enum logic [1:0] {
    MWB_EMPTY = 2'd0,
    MWB_ONE   = 2'd1,
    MWB_FULL  = 2'd2
  } mwb_state_e;

endpackage

// File: rtl/mwb_payload_reg.sv
// Width-parameterised payload register with load enable; zeroed on reset,
// otherwise holds its value until load_i is asserted.
module mwb_payload_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/mem_wb_stage_reg.sv
// MEM/WB pipeline register built as a 2-entry skid buffer with a qualified
// bypass view of the head entry. Define MEMWB_PERF_EN for stall/bubble counters.
module mem_wb_stage_reg #(
  parameter int XLEN   = sysconfig::XLEN,
  parameter int INST_W = sysconfig::INST_LEN,
  parameter int RIDX_W = sysconfig::REG_ADDRWIDTH,
  parameter int CSR_W  = sysconfig::CSR_REG_ADDRWIDTH,
  parameter int TRAP_W = sysconfig::TRAP_BUS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [INST_W-1:0] inst_data_i,
  input  logic [RIDX_W-1:0] rd_idx_i,
  input  logic [XLEN-1:0]   mem_data_i,
  input  logic [CSR_W-1:0]  csr_addr_i,
  input  logic [XLEN-1:0]   exc_csr_data_i,
  input  logic              exc_csr_valid_i,
  input  logic [TRAP_W-1:0] trap_bus_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [XLEN-1:0]   pc_o,
  output logic [INST_W-1:0] inst_data_o,
  output logic [RIDX_W-1:0] rd_idx_o,
  output logic [XLEN-1:0]   wb_data_o,
  output logic [CSR_W-1:0]  csr_addr_o,
  output logic [XLEN-1:0]   exc_csr_data_o,
  output logic [TRAP_W-1:0] trap_bus_o,
  output logic              exc_csr_valid_o,
  output logic [RIDX_W-1:0] byp_rd_idx_o,
  output logic [XLEN-1:0]   byp_data_o,
`ifdef MEMWB_PERF_EN
  output logic [63:0]       stall_cnt_o,
  output logic [63:0]       bubble_cnt_o,
`endif
  output logic [1:0]        dbg_state_o
);

  import sysconfig::*;

  localparam int PAY_W = 3 * XLEN + INST_W + RIDX_W + CSR_W + 1 + TRAP_W;

  // Handshake: a transfer happens on a rising clk edge where valid and ready
  // are both high; valid never waits on ready, and ready/valid driven here
  // come straight from the state register.
  mwb_state_e state_q, state_d;
  logic       in_fire, out_fire;
  logic       main_load, main_from_skid, skid_load;

  logic [PAY_W-1:0] in_pay, main_d, main_q, skid_q;
  logic             main_csr_valid;

  assign in_ready_o  = (state_q != MWB_FULL);
  assign out_valid_o = (state_q != MWB_EMPTY);
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = out_valid_o & out_ready_i;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MWB_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Loads are suppressed on flush so the dropped input never reaches storage.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush_i) begin
      state_d = MWB_EMPTY;
    end else begin
      case (state_q)
        MWB_EMPTY: begin
          if (in_fire) begin
            main_load = 1'b1;
            state_d   = MWB_ONE;
          end
        end
        MWB_ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            skid_load = 1'b1;
            state_d   = MWB_FULL;
          end else if (out_fire) begin
            state_d = MWB_EMPTY;
          end
        end
        MWB_FULL: begin
          if (out_fire) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            state_d        = MWB_ONE;
          end
        end
        default: state_d = MWB_EMPTY;
      endcase
    end
  end

  assign in_pay = {pc_i, inst_data_i, rd_idx_i, mem_data_i, csr_addr_i,
                   exc_csr_data_i, exc_csr_valid_i, trap_bus_i};
  assign main_d = main_from_skid ? skid_q : in_pay;

  mwb_payload_reg #(.W(PAY_W)) u_main (
    .clk    (clk),
    .rst    (rst),
    .load_i (main_load),
    .d_i    (main_d),
    .q_o    (main_q)
  );

  mwb_payload_reg #(.W(PAY_W)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .load_i (skid_load),
    .d_i    (in_pay),
    .q_o    (skid_q)
  );

  assign {pc_o, inst_data_o, rd_idx_o, wb_data_o, csr_addr_o,
          exc_csr_data_o, main_csr_valid, trap_bus_o} = main_q;

  // MAIN keeps stale contents when empty, so the qualified views gate on valid.
  assign exc_csr_valid_o = main_csr_valid & out_valid_o;
  assign byp_rd_idx_o    = out_valid_o ? rd_idx_o : '0;
  assign byp_data_o      = wb_data_o;

`ifdef MEMWB_PERF_EN
  logic [63:0] stall_cnt_q, bubble_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (out_valid_o && !out_ready_i) begin
        stall_cnt_q <= stall_cnt_q + 64'd1;
      end
      if (state_q == MWB_EMPTY) begin
        bubble_cnt_q <= bubble_cnt_q + 64'd1;
      end
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage_reg.sv
// Bench for mem_wb_stage_reg: directed steps then random traffic, checked
// against a depth-2 FIFO reference model.
module tb_mem_wb_stage_reg;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic [63:0] data;
    logic [11:0] csr;
    logic [63:0] csrd;
    logic        csrv;
    logic [63:0] trap;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  ent_t cur_in = '0;

  logic        in_ready_o, out_valid_o, exc_csr_valid_o;
  logic [63:0] pc_o, wb_data_o, exc_csr_data_o, trap_bus_o, byp_data_o;
  logic [31:0] inst_data_o;
  logic [4:0]  rd_idx_o, byp_rd_idx_o;
  logic [11:0] csr_addr_o;
  logic [1:0]  dbg_state_o;
`ifdef MEMWB_PERF_EN
  logic [63:0] stall_cnt_o, bubble_cnt_o;
`endif

  int   total = 0;
  int   bad = 0;
  ent_t exp_q[$];
  ent_t last_head = '0;
  logic [63:0] m_stall = '0;
  logic [63:0] m_bubble = '0;

  always #5 clk = ~clk;

  mem_wb_stage_reg dut (
    .clk             (clk),
    .rst             (rst),
    .flush_i         (flush),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready_o),
    .pc_i            (cur_in.pc),
    .inst_data_i     (cur_in.inst),
    .rd_idx_i        (cur_in.rd),
    .mem_data_i      (cur_in.data),
    .csr_addr_i      (cur_in.csr),
    .exc_csr_data_i  (cur_in.csrd),
    .exc_csr_valid_i (cur_in.csrv),
    .trap_bus_i      (cur_in.trap),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready),
    .pc_o            (pc_o),
    .inst_data_o     (inst_data_o),
    .rd_idx_o        (rd_idx_o),
    .wb_data_o       (wb_data_o),
    .csr_addr_o      (csr_addr_o),
    .exc_csr_data_o  (exc_csr_data_o),
    .trap_bus_o      (trap_bus_o),
    .exc_csr_valid_o (exc_csr_valid_o),
    .byp_rd_idx_o    (byp_rd_idx_o),
    .byp_data_o      (byp_data_o),
`ifdef MEMWB_PERF_EN
    .stall_cnt_o     (stall_cnt_o),
    .bubble_cnt_o    (bubble_cnt_o),
`endif
    .dbg_state_o     (dbg_state_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic ent_t rand_ent();
    ent_t e;
    e.pc   = {$urandom, $urandom};
    e.inst = $urandom;
    e.rd   = 5'($urandom_range(0, 31));
    e.data = {$urandom, $urandom};
    e.csr  = 12'($urandom_range(0, 4095));
    e.csrd = {$urandom, $urandom};
    e.csrv = 1'($urandom_range(0, 1));
    e.trap = {$urandom, $urandom};
    return e;
  endfunction

  task automatic check_all();
    int   n;
    ent_t h;
    n = exp_q.size();
    h = (n > 0) ? exp_q[0] : last_head;
    chk("out_valid", 64'(out_valid_o), 64'(n > 0));
    chk("in_ready", 64'(in_ready_o), 64'(n < 2));
    chk("state", 64'(dbg_state_o), 64'(n));
    chk("pc", pc_o, h.pc);
    chk("inst", 64'(inst_data_o), 64'(h.inst));
    chk("rd", 64'(rd_idx_o), 64'(h.rd));
    chk("wb_data", wb_data_o, h.data);
    chk("csr_addr", 64'(csr_addr_o), 64'(h.csr));
    chk("csr_data", exc_csr_data_o, h.csrd);
    chk("trap", trap_bus_o, h.trap);
    chk("csr_valid", 64'(exc_csr_valid_o), 64'(h.csrv && n > 0));
    chk("byp_rd", 64'(byp_rd_idx_o), (n > 0) ? 64'(h.rd) : 64'd0);
    chk("byp_data", byp_data_o, h.data);
`ifdef MEMWB_PERF_EN
    chk("stall_cnt", stall_cnt_o, m_stall);
    chk("bubble_cnt", bubble_cnt_o, m_bubble);
`endif
  endtask

  // One clock with reset released; the model advances on the same edge.
  task automatic cycle();
    int sz;
    bit inf, outf;
    sz   = exp_q.size();
    inf  = in_valid && (sz < 2);
    outf = out_ready && (sz > 0);
    @(posedge clk);
    if (sz > 0 && !out_ready) m_stall++;
    if (sz == 0) m_bubble++;
    if (flush) begin
      exp_q.delete();
    end else begin
      if (outf) void'(exp_q.pop_front());
      if (inf) exp_q.push_back(cur_in);
    end
    if (exp_q.size() > 0) last_head = exp_q[0];
    #1;
    check_all();
  endtask

  task automatic model_reset();
    exp_q.delete();
    last_head = '0;
    m_stall   = '0;
    m_bubble  = '0;
  endtask

  initial begin
    logic [63:0] snap;

    // Reset held, then released
    repeat (3) @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;

    // Single push: pc=0x80000000, rd=5
    cur_in    = rand_ent();
    cur_in.pc = 64'h8000_0000;
    cur_in.rd = 5'd5;
    in_valid  = 1'b1;
    cycle();
    chk("first_byp_rd", 64'(byp_rd_idx_o), 64'd5);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle();

    // Back-pressure: A then B, an extra attempt while full, then drain
    out_ready = 1'b0;
    in_valid  = 1'b1;
    repeat (3) begin
      cur_in = rand_ent();
      cycle();
    end
    chk("full_in_ready", 64'(in_ready_o), 64'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) cycle();

    // Streaming: 10 back-to-back entries
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cur_in    = rand_ent();
      cur_in.pc = 64'(4 * i);
      cycle();
      chk("stream_in_ready", 64'(in_ready_o), 64'd1);
    end
    in_valid = 1'b0;
    repeat (2) cycle();

    // Flush while FULL with a simultaneous input
    out_ready = 1'b0;
    in_valid  = 1'b1;
    repeat (2) begin
      cur_in = rand_ent();
      cycle();
    end
    flush  = 1'b1;
    cur_in = rand_ent();
    cycle();
    chk("flush_valid", 64'(out_valid_o), 64'd0);
    chk("flush_byp_rd", 64'(byp_rd_idx_o), 64'd0);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) cycle();

    // CSR qualification, with a 7-cycle stall and 3 idle cycles after pop
    out_ready   = 1'b0;
    in_valid    = 1'b1;
    cur_in      = rand_ent();
    cur_in.csrv = 1'b1;
    cycle();
    in_valid = 1'b0;
    snap = m_stall;
    repeat (7) cycle();
    chk("csr_held", 64'(exc_csr_valid_o), 64'd1);
`ifdef MEMWB_PERF_EN
    chk("stall7", stall_cnt_o, snap + 64'd7);
`endif
    out_ready = 1'b1;
    cycle();
    chk("csr_after_pop", 64'(exc_csr_valid_o), 64'd0);
    snap = m_bubble;
    repeat (3) cycle();
`ifdef MEMWB_PERF_EN
    chk("bubble3", bubble_cnt_o, snap + 64'd3);
`endif

    // Asynchronous reset mid-transfer
    out_ready = 1'b0;
    in_valid  = 1'b1;
    repeat (2) begin
      cur_in = rand_ent();
      cycle();
    end
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 19) == 0);
      cur_in    = rand_ent();
      cycle();
    end
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
